// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
//
// Shared types for the EX-stage multiply/divide sequencer.
//   md_state_t  : sequencer state
//   md_req_t    : EX-stage request word (mul_en, div_en, sign), also used by
//                 the hazard unit wiring
//   md_unit_t   : which functional unit an operation belongs to
// Helper functions classify states so the top module reads in terms of
// "busy" / "draining" rather than raw state comparisons.
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    localparam int MD_DW = 32;

    typedef enum logic [2:0] {
        MD_IDLE      = 3'd0,
        MD_BUSY_MUL  = 3'd1,
        MD_BUSY_DIV  = 3'd2,
        MD_DONE      = 3'd3,
        MD_DRAIN_MUL = 3'd4,
        MD_DRAIN_DIV = 3'd5
    } md_state_t;

    typedef struct packed {
        logic mul_en;
        logic div_en;
        logic sign;
    } md_req_t;

    typedef enum logic {
        MD_UNIT_MUL = 1'b0,
        MD_UNIT_DIV = 1'b1
    } md_unit_t;

    // An operation is outstanding in a unit and its result will be kept.
    function automatic logic md_is_busy(input md_state_t s);
        return (s == MD_BUSY_MUL) || (s == MD_BUSY_DIV);
    endfunction

    // An operation is outstanding in a unit but its result will be dropped.
    function automatic logic md_is_drain(input md_state_t s);
        return (s == MD_DRAIN_MUL) || (s == MD_DRAIN_DIV);
    endfunction

    // Unit that owns the outstanding operation in a busy/drain state.
    function automatic md_unit_t md_unit_of(input md_state_t s);
        return ((s == MD_BUSY_DIV) || (s == MD_DRAIN_DIV)) ? MD_UNIT_DIV
                                                           : MD_UNIT_MUL;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_if
//
// Bundle between the sequencer and the multiplier/divider units.
//   mul_in_valid, div_in_valid : one-cycle start pulses (sequencer -> unit)
//   unit_sign                  : latched signed/unsigned flag
//   unit_srca, unit_srcb       : latched operands, stable during an operation
//   mul_out_valid, div_out_valid : result strobes (unit -> sequencer)
//   mul_hi/mul_lo, div_hi/div_lo : unit results
// master : sequencer side, slave : unit side.
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if
    import muldiv_ctrl_pkg::*;
#(
    parameter int DW = MD_DW
) ();

    logic          mul_in_valid;
    logic          div_in_valid;
    logic          unit_sign;
    logic [DW-1:0] unit_srca;
    logic [DW-1:0] unit_srcb;

    logic          mul_out_valid;
    logic          div_out_valid;
    logic [DW-1:0] mul_hi;
    logic [DW-1:0] mul_lo;
    logic [DW-1:0] div_hi;
    logic [DW-1:0] div_lo;

    modport master (
        output mul_in_valid, div_in_valid, unit_sign, unit_srca, unit_srcb,
        input  mul_out_valid, div_out_valid, mul_hi, mul_lo, div_hi, div_lo
    );

    modport slave (
        input  mul_in_valid, div_in_valid, unit_sign, unit_srca, unit_srcb,
        output mul_out_valid, div_out_valid, mul_hi, mul_lo, div_hi, div_lo
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencer for the EX-stage multi-cycle multiplier and divider. When the EX
// instruction is a multiply or divide it latches the operands and sign, fires
// a one-cycle start at the selected unit, and requests a pipeline stall until
// the unit returns its result. The captured HI/LO is then presented with
// res_valid until the instruction leaves EX. If the instruction is flushed
// while its unit is still working, the sequencer waits for (and discards) the
// result before accepting new work, so a later operation never sees a stale
// strobe.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   ex_mul_en, ex_div_en     : EX instruction is a multiply / divide (level)
//   ex_sign                  : signed operation
//   ex_srca, ex_srcb         : forwarded operands
//   ex_advance               : EX instruction moves to MEM at this edge
//   ex_flush                 : EX instruction is killed at this edge
//   unit                     : muldiv_ctrl_if master (start pulses, latched
//                              operands, unit result strobes and data)
//   md_stall                 : stall request to the hazard unit (combinational)
//   res_valid, res_hi, res_lo: captured result for the EX instruction
// ---------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DW = MD_DW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ex_mul_en,
    input  logic          ex_div_en,
    input  logic          ex_sign,
    input  logic [DW-1:0] ex_srca,
    input  logic [DW-1:0] ex_srcb,
    input  logic          ex_advance,
    input  logic          ex_flush,

    muldiv_ctrl_if.master unit,

    output logic          md_stall,
    output logic          res_valid,
    output logic [DW-1:0] res_hi,
    output logic [DW-1:0] res_lo
);

    md_state_t     state_reg;
    md_req_t       req;
    logic          req_any;
    md_unit_t      sel_unit;
    logic          sel_out_valid;
    logic [DW-1:0] sel_hi;
    logic [DW-1:0] sel_lo;

    assign req.mul_en = ex_mul_en;
    assign req.div_en = ex_div_en;
    assign req.sign   = ex_sign;
    assign req_any    = req.mul_en | req.div_en;

    // Only the unit that owns the outstanding operation is listened to; a
    // strobe from the other unit is ignored.
    assign sel_unit      = md_unit_of(state_reg);
    assign sel_out_valid = (sel_unit == MD_UNIT_DIV) ? unit.div_out_valid
                                                     : unit.mul_out_valid;
    assign sel_hi        = (sel_unit == MD_UNIT_DIV) ? unit.div_hi : unit.mul_hi;
    assign sel_lo        = (sel_unit == MD_UNIT_DIV) ? unit.div_lo : unit.mul_lo;

    // Stall while a request is waiting to issue, while a kept operation is
    // running, or while a drain blocks a new request. A flush releases the
    // stall because the instruction being held is leaving anyway. Gating with
    // rst keeps every output low while reset is applied.
    always_comb begin
        md_stall = 1'b0;
        if (!rst && !ex_flush) begin
            unique case (state_reg)
                MD_IDLE:                     md_stall = req_any;
                MD_BUSY_MUL, MD_BUSY_DIV:    md_stall = 1'b1;
                MD_DRAIN_MUL, MD_DRAIN_DIV:  md_stall = req_any;
                default:                     md_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= MD_IDLE;
            unit.mul_in_valid <= 1'b0;
            unit.div_in_valid <= 1'b0;
            unit.unit_sign    <= 1'b0;
            unit.unit_srca    <= '0;
            unit.unit_srcb    <= '0;
            res_valid         <= 1'b0;
            res_hi            <= '0;
            res_lo            <= '0;
        end else begin
            // Start pulses last exactly one cycle.
            unit.mul_in_valid <= 1'b0;
            unit.div_in_valid <= 1'b0;

            unique case (state_reg)
                MD_IDLE: begin
                    if (!ex_flush && req_any) begin
                        unit.unit_sign <= req.sign;
                        unit.unit_srca <= ex_srca;
                        unit.unit_srcb <= ex_srcb;
                        // Multiply wins if the control word asserts both.
                        if (req.mul_en) begin
                            unit.mul_in_valid <= 1'b1;
                            state_reg         <= MD_BUSY_MUL;
                        end else begin
                            unit.div_in_valid <= 1'b1;
                            state_reg         <= MD_BUSY_DIV;
                        end
                    end
                end

                MD_BUSY_MUL, MD_BUSY_DIV: begin
                    if (sel_out_valid) begin
                        if (ex_flush) begin
                            // Result arrives as the instruction dies: nothing
                            // left in flight, so no drain is needed.
                            state_reg <= MD_IDLE;
                        end else begin
                            res_hi    <= sel_hi;
                            res_lo    <= sel_lo;
                            res_valid <= 1'b1;
                            state_reg <= MD_DONE;
                        end
                    end else if (ex_flush) begin
                        state_reg <= (sel_unit == MD_UNIT_DIV) ? MD_DRAIN_DIV
                                                               : MD_DRAIN_MUL;
                    end
                end

                MD_DONE: begin
                    // The enable is still high here; it belongs to the same
                    // instruction, so nothing is reissued until it leaves.
                    if (ex_advance || ex_flush) begin
                        res_valid <= 1'b0;
                        state_reg <= MD_IDLE;
                    end
                end

                MD_DRAIN_MUL, MD_DRAIN_DIV: begin
                    if (sel_out_valid) begin
                        state_reg <= MD_IDLE;
                    end
                end

                default: begin
                    res_valid <= 1'b0;
                    state_reg <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_mul_en, ex_div_en, ex_sign;
    logic [DW-1:0] ex_srca, ex_srcb;
    logic          ex_advance, ex_flush;
    logic          md_stall, res_valid;
    logic [DW-1:0] res_hi, res_lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl_if #(.DW(DW)) unit_bus ();

    muldiv_ctrl #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mul_en  (ex_mul_en),
        .ex_div_en  (ex_div_en),
        .ex_sign    (ex_sign),
        .ex_srca    (ex_srca),
        .ex_srcb    (ex_srcb),
        .ex_advance (ex_advance),
        .ex_flush   (ex_flush),
        .unit       (unit_bus.master),
        .md_stall   (md_stall),
        .res_valid  (res_valid),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn) return 64'(sa * sb);
        return 64'(ua * ub);
    endfunction

    // {hi, lo} = {remainder, quotient}
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_units();
        unit_bus.mul_out_valid = 1'b0;
        unit_bus.div_out_valid = 1'b0;
        unit_bus.mul_hi = $urandom;
        unit_bus.mul_lo = $urandom;
        unit_bus.div_hi = $urandom;
        unit_bus.div_lo = $urandom;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".stall"}, 64'(md_stall), 64'd0);
        chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".res"}, {res_hi, res_lo}, 64'd0);
        chk({tag, ".in_valid"}, {62'd0, unit_bus.mul_in_valid, unit_bus.div_in_valid}, 64'd0);
        chk({tag, ".ops"}, {unit_bus.unit_srca, unit_bus.unit_srcb}, 64'd0);
        chk({tag, ".sign"}, 64'(unit_bus.unit_sign), 64'd0);
    endtask

    // One complete operation starting in the current cycle T (controller idle).
    // The unit answers k cycles after the start cycle; the instruction then
    // sits in DONE for 'hold' extra cycles before advancing.
    task automatic run_op(input string tag, input bit is_mul, input bit both, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input int hold, input bit noise);
        logic [63:0] exp;
        logic [1:0]  exp_iv;
        exp = is_mul ? ref_mul(sgn, a, b) : ref_div(sgn, a, b);
        ex_mul_en = is_mul;
        ex_div_en = !is_mul || both;
        ex_sign = sgn;
        ex_srca = a;
        ex_srcb = b;
        ex_advance = 1'b0;
        ex_flush = 1'b0;
        #1;
        chk({tag, ".T.stall"}, 64'(md_stall), 64'd1);
        chk({tag, ".T.in_valid"}, {62'd0, unit_bus.mul_in_valid, unit_bus.div_in_valid}, 64'd0);
        chk({tag, ".T.res_valid"}, 64'(res_valid), 64'd0);
        for (int c = 1; c <= k; c++) begin
            tick();
            quiet_units();
            exp_iv = (c == 1) ? (is_mul ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("%s.c%0d.in_valid", tag, c), {62'd0, unit_bus.mul_in_valid, unit_bus.div_in_valid}, 64'(exp_iv));
            chk($sformatf("%s.c%0d.ops", tag, c), {unit_bus.unit_srca, unit_bus.unit_srcb}, {a, b});
            chk($sformatf("%s.c%0d.sign", tag, c), 64'(unit_bus.unit_sign), 64'(sgn));
            if (noise) begin
                // strobe from the other unit and stray advances must be ignored
                if (is_mul) unit_bus.div_out_valid = 1'($urandom);
                else        unit_bus.mul_out_valid = 1'($urandom);
                ex_advance = 1'($urandom);
            end
            if (c == k) begin
                if (is_mul) begin
                    unit_bus.mul_out_valid = 1'b1;
                    {unit_bus.mul_hi, unit_bus.mul_lo} = exp;
                end else begin
                    unit_bus.div_out_valid = 1'b1;
                    {unit_bus.div_hi, unit_bus.div_lo} = exp;
                end
            end
            #1;
            chk($sformatf("%s.c%0d.stall", tag, c), 64'(md_stall), 64'd1);
            chk($sformatf("%s.c%0d.res_valid", tag, c), 64'(res_valid), 64'd0);
        end
        tick();
        quiet_units();
        ex_advance = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) tick();
            #1;
            chk($sformatf("%s.done%0d.stall", tag, h), 64'(md_stall), 64'd0);
            chk($sformatf("%s.done%0d.res_valid", tag, h), 64'(res_valid), 64'd1);
            chk($sformatf("%s.done%0d.res", tag, h), {res_hi, res_lo}, exp);
            chk($sformatf("%s.done%0d.in_valid", tag, h), {62'd0, unit_bus.mul_in_valid, unit_bus.div_in_valid}, 64'd0);
        end
        ex_advance = 1'b1;
        tick();
        ex_advance = 1'b0;
        ex_mul_en = 1'b0;
        ex_div_en = 1'b0;
        #1;
        chk({tag, ".after.res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".after.stall"}, 64'(md_stall), 64'd0);
        $display("op %s mul=%0d sign=%0d a=%h b=%h k=%0d hold=%0d hi=%h lo=%h", tag, is_mul, sgn, a, b, k, hold, exp[63:32], exp[31:0]);
    endtask

    initial begin
        logic [31:0] a, b;
        int          k, d;
        bit          m, s;

        rst = 1'b1;
        ex_mul_en = 1'b0; ex_div_en = 1'b0; ex_sign = 1'b0;
        ex_srca = '0; ex_srcb = '0; ex_advance = 1'b0; ex_flush = 1'b0;
        quiet_units();
        repeat (3) tick();
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();
        chk_outputs_zero("post_reset");

        // signed mult -3 * 7, latency 5
        run_op("mult_m3x7", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 5, 0, 1'b0);
        // divu 100/7, DONE held 3 extra cycles
        run_op("divu_100_7", 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 4, 3, 1'b0);
        // both enables: multiply must win
        run_op("both_en", 1'b1, 1'b1, 1'b0, 32'd12345, 32'd678, 3, 1, 1'b0);
        // out_valid in the in_valid cycle
        run_op("k1_div", 1'b0, 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1, 0, 1'b0);

        // randomized operations with noise on the other unit and ex_advance
        for (int i = 0; i < 10; i++) begin
            m = 1'($urandom);
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) b = 32'd7;
            k = $urandom_range(1, 6);
            run_op($sformatf("rnd%0d", i), m, 1'b0, s, a, b, k, $urandom_range(0, 2), 1'b1);
        end

        // flush in the 2nd BUSY_DIV cycle, new mult behind it
        ex_div_en = 1'b1; ex_mul_en = 1'b0; ex_sign = 1'b0;
        ex_srca = 32'd1000; ex_srcb = 32'd3;
        #1;
        chk("fl.T.stall", 64'(md_stall), 64'd1);
        tick();
        chk("fl.T1.div_in_valid", 64'(unit_bus.div_in_valid), 64'd1);
        tick();
        ex_flush = 1'b1;
        #1;
        chk("fl.T2.stall_flush", 64'(md_stall), 64'd0);
        tick();
        ex_flush = 1'b0; ex_div_en = 1'b0;
        #1;
        chk("fl.drain_noen.stall", 64'(md_stall), 64'd0);
        chk("fl.drain.res_valid", 64'(res_valid), 64'd0);
        d = $urandom_range(1, 3);
        for (int i = 0; i <= d; i++) begin
            tick();
            quiet_units();
            ex_mul_en = 1'b1; ex_sign = 1'b1;
            ex_srca = 32'hFFFF_FFF0; ex_srcb = 32'd9;
            if (i == 0) unit_bus.mul_out_valid = 1'b1;     // wrong unit, ignored
            if (i == d) begin
                unit_bus.div_out_valid = 1'b1;
                unit_bus.div_hi = 32'hDEAD_BEEF;
                unit_bus.div_lo = 32'hBAD0_BAD0;
            end
            #1;
            chk($sformatf("fl.drain%0d.stall", i), 64'(md_stall), 64'd1);
            chk($sformatf("fl.drain%0d.in_valid", i), {62'd0, unit_bus.mul_in_valid, unit_bus.div_in_valid}, 64'd0);
            chk($sformatf("fl.drain%0d.res_valid", i), 64'(res_valid), 64'd0);
        end
        tick();
        quiet_units();
        run_op("after_drain", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd9, 2, 0, 1'b0);

        // flush coinciding with mul_out_valid: straight back to IDLE
        ex_mul_en = 1'b1; ex_sign = 1'b0; ex_srca = 32'd5; ex_srcb = 32'd6;
        tick();
        chk("flv.T1.mul_in_valid", 64'(unit_bus.mul_in_valid), 64'd1);
        tick();
        ex_flush = 1'b1;
        unit_bus.mul_out_valid = 1'b1;
        unit_bus.mul_hi = 32'h1111_2222;
        unit_bus.mul_lo = 32'h3333_4444;
        #1;
        chk("flv.T2.stall", 64'(md_stall), 64'd0);
        tick();
        quiet_units();
        ex_flush = 1'b0; ex_mul_en = 1'b0;
        #1;
        chk("flv.T3.res_valid", 64'(res_valid), 64'd0);
        chk("flv.T3.stall", 64'(md_stall), 64'd0);
        run_op("flv_next_div", 1'b0, 1'b0, 1'b0, 32'd77, 32'd5, 2, 0, 1'b0);

        // asynchronous reset in the middle of BUSY_MUL
        run_op("pre_rst", 1'b1, 1'b0, 1'b0, 32'd40, 32'd50, 1, 0, 1'b0);
        ex_mul_en = 1'b1; ex_sign = 1'b1; ex_srca = 32'hABCD_0123; ex_srcb = 32'h0000_0456;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        tick();
        rst = 1'b0;
        ex_mul_en = 1'b0;
        tick();
        chk_outputs_zero("rst_release");
        run_op("post_rst_div", 1'b0, 1'b0, 1'b1, 32'hFFFF_FC18, 32'd33, 3, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule
